ahb_slave_ws_mem: RTL
=====================

AHB_SLAVE_WS_MEM -- requirements
Module: ahb_slave_ws_mem

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
  AWIDTH, 12, HADDR width in bits
  DWIDTH, 32, data bus width in bits; legal values 32 or 64
  DEPTH, 1024, memory depth in DWIDTH-bit words
  RD_WAIT, 0, wait states inserted on every read (0-15)
  WR_WAIT, 0, wait states inserted on every write (0-15)
  ERR_EN, 0, 1 enables the error window
  ERR_BASE, 'h800, first byte address of the error window
  ERR_SIZE, 'h100, error window size in bytes
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
  HCLK  in  1  sole clock; all logic on the rising edge
  HRESET  in  1  asynchronous reset, active-high
  HSEL  in  1  slave select
  HADDR  in  AWIDTH  byte address
  HWRITE  in  1  1 = write
  HTRANS  in  2  transfer type
  HSIZE  in  3  transfer size
  HBURST  in  3  burst type (ignored)
  HWDATA  in  DWIDTH  write data
  HREADYIN  in  1  bus ready
  HRDATA  out  DWIDTH  read data
  HREADYOUT  out  1  slave ready
  HRESP  out  1  0 = OKAY, 1 = ERROR
  TXCNT  out  16  count of completed OKAY transfers
  ERRCNT  out  8  count of ERROR responses

Function
REQ-003 A transfer SHALL be accepted on a rising edge with HSEL=1, HREADYIN=1 and HTRANS[1]=1. IDLE and BUSY SHALL get a zero-wait OKAY and have no side effects.
REQ-004 On acceptance the block SHALL register HADDR, HWRITE and HSIZE for the data phase.
REQ-005 The FSM SHALL have four states: IDLE, WAIT, ERR1 and ERR2.
REQ-006 An accepted transfer SHALL be classified as an error if any of the following holds:
  HSIZE > log2(DWIDTH/8)
  HADDR is unaligned to HSIZE
  word index HADDR[AWIDTH-1:log2(DWIDTH/8)] >= DEPTH
  ERR_EN=1 and ERR_BASE <= HADDR < ERR_BASE+ERR_SIZE
REQ-007 Error transfers SHALL go IDLE->ERR1->ERR2->IDLE:
  ERR1: HREADYOUT=0, HRESP=1
  ERR2: HREADYOUT=1, HRESP=1
  memory SHALL NOT be written, and no wait states SHALL be inserted
REQ-008 A non-error transfer with N = RD_WAIT or WR_WAIT SHALL hold HREADYOUT=0 for exactly N data-phase cycles (state WAIT, 4-bit down-counter), then HREADYOUT=1 with HRESP=0 for one cycle. When N=0 the transfer SHALL complete in its first data-phase cycle.
REQ-009 A write SHALL update only the byte lanes selected by HSIZE and the low address bits (little-endian). The update SHALL happen on the edge that ends the final data-phase cycle, using the HWDATA present in that cycle.
REQ-010 During the final cycle of a read data phase, HRDATA SHALL carry the full addressed word. In all other cycles HRDATA SHALL be 0.
REQ-011 A new address phase SHALL be accepted in the same cycle that the previous data phase completes (HREADYOUT=1), so back-to-back transfers have no idle gap.
REQ-012 A read issued directly after a write to the same word SHALL return the newly written data.
REQ-013 TXCNT SHALL increment by 1 on each OKAY completion of a NONSEQ or SEQ transfer, wrapping from 65535 to 0.
REQ-014 ERRCNT SHALL increment on each ERR2 cycle and saturate at 255.
REQ-015 A transfer accepted in the ERR1 cycle SHALL be ignored, because HREADYIN=0 during that cycle.

Reset
REQ-016 While HRESET=1, and asynchronously on its assertion, the block SHALL force:
  FSM to IDLE
  HREADYOUT=1, HRESP=0, HRDATA=0
  TXCNT=0, ERRCNT=0, wait counter 0
REQ-017 Reset asserted mid-transfer SHALL abort that transfer; a pending write SHALL NOT occur.
REQ-018 Memory contents SHALL NOT be cleared by reset.
REQ-019 The first transfer SHALL be accepted on the first rising edge after HRESET deasserts.

Verification
REQ-020 Word write 0xA5A5_1234 to 0x010, then read 0x010 with WR_WAIT=RD_WAIT=0 -> both complete with no wait cycles; HRDATA=0xA5A5_1234; TXCNT=2.
REQ-021 Byte write 0xFF to 0x013 over word 0x0000_0000, then word read -> 0xFF00_0000.
REQ-022 RD_WAIT=3, read 0x020 -> HREADYOUT low for exactly 3 cycles, data on the 4th; WR_WAIT=2 write -> HREADYOUT low for exactly 2 cycles.
REQ-023 ERR_EN=1, write to 0x880 -> ERR1/ERR2 pattern; a subsequent read of 0x880 -> ERROR, and HRDATA=0 for that read; ERRCNT=2; TXCNT unchanged.
REQ-024 Halfword at 0x001, or HSIZE=3 with DWIDTH=32 -> two-cycle ERROR response and no memory change.
REQ-025 HRESET asserted during the 2nd wait cycle of a WR_WAIT=3 write -> HREADYOUT=1 immediately, TXCNT=0, and the target word is unchanged.

Source files
------------

// File: rtl/ahb_slave_ws_mem.sv
// AHB-Lite slave memory with configurable wait states and an optional error window.
//
// Ports:
//   HCLK, HRESET            clock (rising edge) and asynchronous active-high reset
//   HSEL, HADDR, HWRITE,    address-phase inputs; a transfer is taken when HSEL,
//   HTRANS, HSIZE, HBURST   HREADYIN and HTRANS[1] are all high (HBURST is ignored)
//   HWDATA, HREADYIN        write data and bus ready
//   HRDATA                  read data, nonzero only in the final cycle of a read
//   HREADYOUT, HRESP        slave ready / response (1 = ERROR)
//   TXCNT                   completed OKAY transfers, wraps at 16 bits
//   ERRCNT                  ERROR responses, saturates at 255
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | bus ready; when act_q is set this is the final data-phase cycle
// WAIT   | wait states of an OKAY transfer, cnt_q counts down to 1
// ERR1   | first error cycle: HREADYOUT=0, HRESP=1
// ERR2   | second error cycle: HREADYOUT=1, HRESP=1, next transfer may start
module ahb_slave_ws_mem #(
    parameter int          AWIDTH   = 12,
    parameter int          DWIDTH   = 32,
    parameter int          DEPTH    = 1024,
    parameter int          RD_WAIT  = 0,
    parameter int          WR_WAIT  = 0,
    parameter int          ERR_EN   = 0,
    parameter int unsigned ERR_BASE = 'h800,
    parameter int unsigned ERR_SIZE = 'h100
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [AWIDTH-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DWIDTH-1:0] HWDATA,
    input  logic              HREADYIN,
    output logic [DWIDTH-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [15:0]       TXCNT,
    output logic [7:0]        ERRCNT
);

    localparam int NBYTES = DWIDTH / 8;
    localparam int ALSB   = $clog2(NBYTES);
    localparam int MW     = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              act_q, act_d;
    logic [AWIDTH-1:0] a_addr;
    logic              a_write;
    logic [2:0]        a_size;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              bus_ready, accept, final_ok, wr_go, rd_go;
    logic              size_err, align_err, range_err, win_err, xfer_err;
    logic [AWIDTH-1:0] align_mask;
    logic [3:0]        n_sel;
    logic [MW-1:0]     mem_idx;
    logic [7:0]        lane_lo;
    logic [8:0]        lane_hi;
    logic [NBYTES-1:0] be;

    logic unused_ok;
    assign unused_ok = ^{HBURST, HTRANS[0]};

    // ERR1 is the only non-waiting state where the bus is stalled; WAIT stalls too.
    assign bus_ready = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign accept    = HSEL && HREADYIN && HTRANS[1] && bus_ready;
    assign final_ok  = (state_q == S_IDLE) && act_q;
    assign wr_go     = final_ok && a_write;
    assign rd_go     = final_ok && !a_write;

    assign size_err   = HSIZE > 3'(ALSB);
    assign align_mask = (AWIDTH'(1) << HSIZE) - AWIDTH'(1);
    assign align_err  = |(HADDR & align_mask);
    assign range_err  = 32'(HADDR[AWIDTH-1:ALSB]) >= 32'(DEPTH);
    assign win_err    = (ERR_EN != 0) && (32'(HADDR) >= ERR_BASE)
                        && (32'(HADDR) < ERR_BASE + ERR_SIZE);
    assign xfer_err   = size_err || align_err || range_err || win_err;

    assign n_sel = HWRITE ? 4'(WR_WAIT) : 4'(RD_WAIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        unique case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_IDLE;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE and ERR2: any data phase finishes here, a new one may start
                state_d = S_IDLE;
                act_d   = 1'b0;
                if (accept) begin
                    if (xfer_err) begin
                        state_d = S_ERR1;
                    end else begin
                        act_d = 1'b1;
                        if (n_sel != 4'd0) begin
                            state_d = S_WAIT;
                            cnt_d   = n_sel;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            act_q   <= 1'b0;
            a_addr  <= '0;
            a_write <= 1'b0;
            a_size  <= 3'd0;
            TXCNT   <= 16'd0;
            ERRCNT  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            if (accept) begin
                a_addr  <= HADDR;
                a_write <= HWRITE;
                a_size  <= HSIZE;
            end
            if (final_ok) TXCNT <= TXCNT + 16'd1;
            if ((state_q == S_ERR2) && (ERRCNT != 8'hFF)) ERRCNT <= ERRCNT + 8'd1;
        end
    end

    assign mem_idx = a_addr[ALSB +: MW];
    assign lane_lo = 8'(a_addr[ALSB-1:0]);
    assign lane_hi = {1'b0, lane_lo} + (9'd1 << a_size);

    always_comb begin
        be = '0;
        for (int i = 0; i < NBYTES; i++) begin
            be[i] = (8'(i) >= lane_lo) && (9'(i) < lane_hi);
        end
    end

    // act_q is cleared asynchronously, so a reset mid-transfer blocks the write.
    always_ff @(posedge HCLK) begin
        if (wr_go) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i]) mem[mem_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA    = rd_go ? mem[mem_idx] : '0;
    assign HREADYOUT = bus_ready;
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);

endmodule
